// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter and pending long-write scoreboard.
// Optional anti-starvation counter: define RF_ARB_ANTISTARVE_EN.
module rf_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int RFIDX_WIDTH  = 5,
    parameter int ADDR_SIZE    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        p_we,
    input  logic [RFIDX_WIDTH-1:0]      p_wa,
    input  logic [XLEN-1:0]             p_wd,
    input  logic [ADDR_SIZE-1:0]        p_pc,
    output logic                        p_stall,
    input  logic                        iss_valid,
    input  logic [RFIDX_WIDTH-1:0]      iss_rd,
    input  logic                        m_valid,
    input  logic [RFIDX_WIDTH-1:0]      m_wa,
    input  logic [XLEN-1:0]             m_wd,
    input  logic [ADDR_SIZE-1:0]        m_pc,
    output logic                        m_ready,
    output logic                        we3,
    output logic [RFIDX_WIDTH-1:0]      wa3,
    output logic [XLEN-1:0]             wd3,
    output logic [ADDR_SIZE-1:0]        pc,
    output logic [(1<<RFIDX_WIDTH)-1:0] pend
);

    localparam int NREG = 1 << RFIDX_WIDTH;

    logic            pipe_claim;
    logic            force_long;
    logic            handshake;
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    assign pipe_claim = p_we && (p_wa != '0);

`ifdef RF_ARB_ANTISTARVE_EN
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_q;

    assign force_long = m_valid && (starve_q == CW'(STARVE_LIMIT));

    // Counts consecutive denied cycles; saturates so the force holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else if (!m_valid || handshake) begin
            starve_q <= '0;
        end else if (starve_q != CW'(STARVE_LIMIT)) begin
            starve_q <= starve_q + 1'b1;
        end
    end
`else
    assign force_long = 1'b0;
`endif

    always_comb begin
        m_ready   = 1'b0;
        p_stall   = 1'b0;
        handshake = 1'b0;
        we3       = 1'b0;
        wa3       = '0;
        wd3       = '0;
        pc        = '0;
        if (!reset) begin
            m_ready   = force_long || !pipe_claim;
            p_stall   = force_long;
            handshake = m_valid && m_ready;
            if (pipe_claim && !force_long) begin
                we3 = 1'b1;
                wa3 = p_wa;
                wd3 = p_wd;
                pc  = p_pc;
            end else if (handshake) begin
                we3 = (m_wa != '0);
                wa3 = m_wa;
                wd3 = m_wd;
                pc  = m_pc;
            end
        end
    end

    // Clear first so a same-cycle issue to the same register wins.
    always_comb begin
        pend_d = pend_q;
        if (handshake) begin
            pend_d[m_wa] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            pend_d[iss_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and pending-write scoreboard for the core's three-ported register file. Shares the single write port (we3/wa3/wd3/pc) between the in-order pipeline writeback and a long-latency unit (MDU/load miss path) using a valid/ready handshake. Tracks which registers have an outstanding long-latency write so hazard logic can stall dependent instructions. Sits between the writeback stage, the long-latency unit and regfile.

## Interface
- `XLEN`, 32, data width
- `RFIDX_WIDTH`, 5, register index width
- `ADDR_SIZE`, 32, pc width
- `STARVE_LIMIT`, 4, consecutive denied cycles before the long unit is forced onto the port (anti-starvation build only)

- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-high reset
- `p_we`  in  1  pipeline writeback enable
- `p_wa`  in  RFIDX_WIDTH  pipeline destination register
- `p_wd`  in  XLEN  pipeline write data
- `p_pc`  in  ADDR_SIZE  pc of pipeline writer
- `p_stall`  out  1  pipeline must hold writeback this cycle; its write is dropped
- `iss_valid`  in  1  long-latency op issued this cycle
- `iss_rd`  in  RFIDX_WIDTH  destination of issued op
- `m_valid`  in  1  long unit result valid
- `m_wa`  in  RFIDX_WIDTH  long unit destination
- `m_wd`  in  XLEN  long unit data
- `m_pc`  in  ADDR_SIZE  pc of long op
- `m_ready`  out  1  long unit result accepted this cycle
- `we3`, `wa3`, `wd3`, `pc`  out  1/RFIDX_WIDTH/XLEN/ADDR_SIZE  regfile write port
- `pend`  out  2^RFIDX_WIDTH  per-register outstanding long-write bit; bit 0 always 0

## Operation
- Pipeline claims the port when `p_we && p_wa!=0`; a write to x0 is no claim.
- Default priority: pipeline claim wins; `m_ready = !pipe_claim` (independent of `m_valid`).
- Port mux: pipeline granted -> port driven from `p_*`, `we3=1`; else long unit accepted (`m_valid && m_ready`) -> port from `m_*`, `we3 = (m_wa!=0)`; else `we3=0`, `wa3/wd3/pc` = 0.
- Accepted long result with `m_wa==0`: handshake completes, no write, no scoreboard change.
- Scoreboard: on posedge, `iss_valid && iss_rd!=0` sets `pend[iss_rd]`; long-unit handshake clears `pend[m_wa]`. Same index set and cleared in one cycle -> set wins. Issue to already-pending register -> bit stays 1. Pipeline writes never touch `pend`.
- Reset: `pend=0`, starve counter 0; while `reset` high `we3=0`, `m_ready=0`, `p_stall=0` (combinationally forced). Reset mid-operation discards all pending bits; in-flight results are the long unit's responsibility.

## Timing
- Port outputs are combinational from inputs and state: zero-cycle latency from request to write; regfile samples on falling edge of the same cycle.
- `pend` changes on rising edge; visible the cycle after issue/handshake.
- Handshake transfers exactly on cycles with `m_valid && m_ready`; `m_*` must be held stable while `m_valid && !m_ready`.

## Configuration
- `RF_ARB_ANTISTARVE_EN` defined: saturating counter increments each cycle with `m_valid && !m_ready`, clears on handshake or `!m_valid`. When counter == `STARVE_LIMIT`, force: long unit granted, `m_ready=1`, `p_stall=1`, pipeline write dropped that cycle; counter clears after the handshake.
- Not defined: no counter, `p_stall` tied 0, long unit may wait indefinitely behind continuous pipeline writes.

## Test plan
- Reset high with `p_we=1,p_wa=5` -> `we3=0`, `pend=0`; release -> `we3=1,wa3=5` same cycle.
- `p_we=1,p_wa=3,wd=0x11` and `m_valid=1,m_wa=7` together -> port writes x3=0x11, `m_ready=0`; next cycle `p_we=0` -> x7 written, `m_ready=1`.
- `p_we=1,p_wa=0` with `m_valid=1,m_wa=9` -> x9 written, `m_ready=1`.
- `iss_valid,iss_rd=12` -> `pend[12]=1` next cycle; handshake `m_wa=12` with simultaneous `iss_rd=12` -> `pend[12]` stays 1; later handshake alone -> 0.
- `iss_rd=0` -> `pend` unchanged; `m_wa=0` handshake -> `we3=0`, `m_ready=1`.
- With `RF_ARB_ANTISTARVE_EN`, `STARVE_LIMIT=4`: pipeline writes x1 every cycle, `m_valid` held -> denied 4 cycles, 5th cycle `p_stall=1`, `m_ready=1`, long result written; without macro `m_ready` stays 0 for the full burst.
